// File: rtl/spi_master_if.sv
// Control/status and SPI pin bundle for the single-byte mode-0 SPI initiator.
// The master modport is the initiator's view; the slave modport is the controller/far-end view.
interface spi_master_if;
   localparam int unsigned DATA_W = 8;

   logic              start;
   logic [DATA_W-1:0] din;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] dout;
   logic              sck;
   logic              mosi;
   logic              miso;
   logic              ss;

   modport master (
      input  start, din, miso,
      output sck, mosi, ss, busy, done, dout
   );

   modport slave (
      output start, din, miso,
      input  sck, mosi, ss, busy, done, dout
   );
endinterface

// File: rtl/spi_master.sv
// Single-byte SPI initiator, mode 0, MSB first. SCK, SS setup/hold and the
// inter-transfer gap are all timed by one divider of CLK_DIV clk cycles.
module spi_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,   // active-low, asynchronous
   spi_master_if.master bus
);

   localparam int unsigned DIV_W  = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 8;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BITS     = CNT_W'(DATA_W);

   generate
      if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
         $error("spi_master: CLK_DIV must be in 2..255");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT_HI,
      S_SHIFT_LO,
      S_GAP
   } state_t;

   state_t              r_state;
   logic [DIV_W-1:0]    r_div;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic [DATA_W-2:0]   r_tx;
   logic [DATA_W-1:0]   r_rx;
   logic                r_sck;
   logic                r_mosi;
   logic                r_ss;
   logic                r_busy;
   logic                r_done;
   logic [DATA_W-1:0]   r_dout;

   state_t              w_state;
   logic [DIV_W-1:0]    w_div;
   logic [CNT_W-1:0]    w_bit_cnt;
   logic [DATA_W-2:0]   w_tx;
   logic [DATA_W-1:0]   w_rx;
   logic                w_sck;
   logic                w_mosi;
   logic                w_ss;
   logic                w_busy;
   logic                w_done;
   logic [DATA_W-1:0]   w_dout;
   logic                w_tick;

   assign w_tick = (r_div == DIV_LAST);

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state   <= S_IDLE;
         r_div     <= '0;
         r_bit_cnt <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_sck     <= 1'b0;
         r_mosi    <= 1'b0;
         r_ss      <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_dout    <= '0;
      end else begin
         r_state   <= w_state;
         r_div     <= w_div;
         r_bit_cnt <= w_bit_cnt;
         r_tx      <= w_tx;
         r_rx      <= w_rx;
         r_sck     <= w_sck;
         r_mosi    <= w_mosi;
         r_ss      <= w_ss;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_dout    <= w_dout;
      end
   end

   // Next-state and next-output logic; the divider reloads on every state change
   always_comb begin
      w_state   = r_state;
      w_div     = w_tick ? '0 : r_div + DIV_W'(1);
      w_bit_cnt = r_bit_cnt;
      w_tx      = r_tx;
      w_rx      = r_rx;
      w_sck     = r_sck;
      w_mosi    = r_mosi;
      w_ss      = r_ss;
      w_busy    = r_busy;
      w_done    = 1'b0;
      w_dout    = r_dout;

      case (r_state)
         S_IDLE: begin
            w_div = '0;
            if (bus.start) begin
               w_state   = S_SETUP;
               w_tx      = bus.din[DATA_W-2:0];
               w_mosi    = bus.din[DATA_W-1];
               w_ss      = 1'b0;
               w_busy    = 1'b1;
               w_bit_cnt = '0;
            end
         end

         S_SETUP: begin
            if (w_tick) begin
               w_state   = S_SHIFT_HI;
               w_sck     = 1'b1;
               w_rx      = {r_rx[DATA_W-2:0], bus.miso};
               w_bit_cnt = r_bit_cnt + CNT_W'(1);
            end
         end

         S_SHIFT_HI: begin
            if (w_tick) begin
               w_state = S_SHIFT_LO;
               w_sck   = 1'b0;
               if (r_bit_cnt != BITS) begin
                  w_mosi = r_tx[DATA_W-2];
                  w_tx   = {r_tx[DATA_W-3:0], 1'b0};
               end
            end
         end

         S_SHIFT_LO: begin
            if (w_tick) begin
               if (r_bit_cnt == BITS) begin
                  w_state = S_GAP;
                  w_ss    = 1'b1;
                  w_dout  = r_rx;
                  w_done  = 1'b1;
               end else begin
                  // miso is driven from this clk domain, so no synchronizer
                  w_state   = S_SHIFT_HI;
                  w_sck     = 1'b1;
                  w_rx      = {r_rx[DATA_W-2:0], bus.miso};
                  w_bit_cnt = r_bit_cnt + CNT_W'(1);
               end
            end
         end

         S_GAP: begin
            if (w_tick) begin
               w_state = S_IDLE;
               w_busy  = 1'b0;
            end
         end

         default: begin
            w_state = S_IDLE;
            w_div   = '0;
         end
      endcase
   end

   assign bus.sck  = r_sck;
   assign bus.mosi = r_mosi;
   assign bus.ss   = r_ss;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.dout = r_dout;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, behavioural slave, tied miso,
// ignored restarts, mid-transfer reset and back-to-back transfers at CLK_DIV=2.
module tb_spi_master;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   always #5 clk = ~clk;

   spi_master_if ifa ();
   spi_master_if ifb ();

   spi_master #(.CLK_DIV(4)) u_dut_a (.i_clk(clk), .i_rst(rst_a), .bus(ifa));
   spi_master #(.CLK_DIV(2)) u_dut_b (.i_clk(clk), .i_rst(rst_b), .bus(ifb));

   // miso source for instance A: 0 loopback, 1 slave model, 2 tied 0, 3 tied 1
   int unsigned miso_sel = 0;
   logic        slv_miso = 1'b0;
   logic [7:0]  slv_tx   = 8'h00;
   logic [7:0]  slv_rx   = 8'h00;

   assign ifa.miso = (miso_sel == 0) ? ifa.mosi :
                     (miso_sel == 1) ? slv_miso :
                     (miso_sel == 3) ? 1'b1 : 1'b0;
   assign ifb.miso = ifb.mosi;

   // Behavioural mode-0 slave
   always @(negedge ifa.ss) slv_miso = slv_tx[7];
   always @(posedge ifa.sck) if (ifa.ss === 1'b0) slv_rx = {slv_rx[6:0], ifa.mosi};
   always @(negedge ifa.sck) if (ifa.ss === 1'b0) begin
      slv_tx   = {slv_tx[6:0], 1'b0};
      slv_miso = slv_tx[7];
   end

   int         n_checks = 0;
   int         n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pin monitor for instance A
   int         rise_cnt  = 0;
   int         done_cnt  = 0;
   int         align_err = 0;
   int         wide_err  = 0;
   logic [7:0] mosi_bits = 8'h00;
   logic       prev_sck  = 1'b0;
   logic       prev_ss   = 1'b1;
   logic       prev_done = 1'b0;

   always @(posedge clk) begin
      #1;
      if (ifa.sck && !prev_sck && !ifa.ss) begin
         rise_cnt++;
         mosi_bits = {mosi_bits[6:0], ifa.mosi};
      end
      if (ifa.done) begin
         done_cnt++;
         if (!(ifa.ss && !prev_ss)) align_err++;
         if (prev_done) wide_err++;
      end
      prev_sck  = ifa.sck;
      prev_ss   = ifa.ss;
      prev_done = ifa.done;
   end

   task automatic clear_mon();
      rise_cnt  = 0;
      done_cnt  = 0;
      align_err = 0;
      wide_err  = 0;
      mosi_bits = 8'h00;
   endtask

   // One transfer on A; times are clk edges after the accepting edge
   task automatic xfer_a(input logic [7:0] d, input int pulse1, input int pulse2,
                         output int t_done, output int t_idle);
      @(negedge clk);
      clear_mon();
      ifa.din   = d;
      ifa.start = 1'b1;
      @(posedge clk);
      #1;
      ifa.start = 1'b0;
      chk("busy_after_accept", 32'(ifa.busy), 32'd1);
      t_done = -1;
      t_idle = -1;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk);
         #1;
         ifa.start = (n == pulse1 || n == pulse2);
         if (ifa.done && t_done < 0) t_done = n;
         if (!ifa.busy) begin
            t_idle = n;
            break;
         end
      end
      ifa.start = 1'b0;
   endtask

   int t_done;
   int t_idle;
   int t0;
   int k;
   int gap;
   int done_t [2];
   logic [7:0] dout_v [2];

   initial begin
      rst_a     = 1'b0;
      rst_b     = 1'b0;
      ifa.start = 1'b0;
      ifa.din   = 8'h00;
      ifb.start = 1'b0;
      ifb.din   = 8'h00;
      #12;
      chk("rst_ss",   32'(ifa.ss),   32'd1);
      chk("rst_sck",  32'(ifa.sck),  32'd0);
      chk("rst_mosi", 32'(ifa.mosi), 32'd0);
      chk("rst_busy", 32'(ifa.busy), 32'd0);
      chk("rst_done", 32'(ifa.done), 32'd0);
      chk("rst_dout", 32'(ifa.dout), 32'h00);
      chk("rst_b_ss", 32'(ifb.ss),   32'd1);
      @(negedge clk);
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (2) @(posedge clk);

      // Loopback 0xA5
      miso_sel = 0;
      xfer_a(8'hA5, 0, 0, t_done, t_idle);
      chk("lb_done_time", 32'(t_done), 32'd68);
      chk("lb_idle_time", 32'(t_idle), 32'd72);
      chk("lb_dout",      32'(ifa.dout), 32'hA5);
      chk("lb_rises",     32'(rise_cnt), 32'd8);
      chk("lb_mosi_bits", 32'(mosi_bits), 32'hA5);
      chk("lb_done_cnt",  32'(done_cnt), 32'd1);

      // Behavioural slave
      miso_sel = 1;
      slv_tx   = 8'h3C;
      slv_rx   = 8'h00;
      xfer_a(8'hC3, 0, 0, t_done, t_idle);
      chk("slv_master_dout", 32'(ifa.dout), 32'h3C);
      chk("slv_rx",          32'(slv_rx), 32'hC3);
      chk("slv_done_cnt",    32'(done_cnt), 32'd1);
      chk("slv_done_align",  32'(align_err), 32'd0);
      chk("slv_done_width",  32'(wide_err), 32'd0);

      // Tied miso
      miso_sel = 3;
      xfer_a(8'h00, 0, 0, t_done, t_idle);
      chk("tie1_dout",      32'(ifa.dout), 32'hFF);
      chk("tie1_mosi_bits", 32'(mosi_bits), 32'h00);
      chk("tie1_rises",     32'(rise_cnt), 32'd8);
      miso_sel = 2;
      xfer_a(8'hFF, 0, 0, t_done, t_idle);
      chk("tie0_dout",      32'(ifa.dout), 32'h00);
      chk("tie0_mosi_bits", 32'(mosi_bits), 32'hFF);

      // Start re-pulsed while busy
      miso_sel = 0;
      xfer_a(8'h5A, 10, 40, t_done, t_idle);
      chk("repulse_done_cnt",  32'(done_cnt), 32'd1);
      chk("repulse_rises",     32'(rise_cnt), 32'd8);
      chk("repulse_dout",      32'(ifa.dout), 32'h5A);
      chk("repulse_idle_time", 32'(t_idle), 32'd72);
      repeat (3) @(posedge clk);
      #1;
      chk("repulse_no_queue", 32'(ifa.busy), 32'd0);

      // Reset mid-transfer
      @(negedge clk);
      clear_mon();
      ifa.din   = 8'h99;
      ifa.start = 1'b1;
      @(posedge clk);
      #1;
      ifa.start = 1'b0;
      repeat (29) @(posedge clk);
      #2;
      chk("midrst_pre_busy", 32'(ifa.busy), 32'd1);
      rst_a = 1'b0;
      #1;
      chk("midrst_ss",   32'(ifa.ss),   32'd1);
      chk("midrst_sck",  32'(ifa.sck),  32'd0);
      chk("midrst_busy", 32'(ifa.busy), 32'd0);
      chk("midrst_dout", 32'(ifa.dout), 32'h00);
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_no_done", 32'(done_cnt), 32'd0);
      @(negedge clk);
      rst_a = 1'b1;
      xfer_a(8'h81, 0, 0, t_done, t_idle);
      chk("post_rst_dout",      32'(ifa.dout), 32'h81);
      chk("post_rst_done_time", 32'(t_done), 32'd68);

      // CLK_DIV=2, start held high, back-to-back
      @(negedge clk);
      ifb.din   = 8'h11;
      ifb.start = 1'b1;
      t0  = -1;
      k   = 0;
      gap = 0;
      done_t[0] = -1;
      done_t[1] = -1;
      dout_v[0] = 8'h00;
      dout_v[1] = 8'h00;
      for (int n = 0; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (t0 < 0 && ifb.busy) begin
            t0 = n;
            ifb.din = 8'h22;
         end
         if (ifb.done && k < 2) begin
            done_t[k] = n;
            dout_v[k] = ifb.dout;
            k++;
         end
         if (k == 1 && ifb.ss) gap++;
         if (k == 2) begin
            ifb.start = 1'b0;
            break;
         end
      end
      ifb.start = 1'b0;
      chk("b2b_done_cnt",  32'(k), 32'd2);
      chk("b2b_first_lat", 32'(done_t[0] - t0), 32'd34);
      chk("b2b_spacing",   32'(done_t[1] - done_t[0]), 32'd37);
      chk("b2b_dout0",     32'(dout_v[0]), 32'h11);
      chk("b2b_dout1",     32'(dout_v[1]), 32'h22);
      chk("b2b_ss_gap",    32'(gap >= 2), 32'd1);
      for (int n = 0; n < 20 && ifb.busy; n++) @(posedge clk);
      #1;
      chk("b2b_final_idle", 32'(ifb.busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first; the controlling end of the byte-oriented SPI slave link in this design.
- Drives SS, SCK and MOSI from the system clock and captures MISO.
- Returns the received byte with a one-cycle done pulse.
- A counter divider generates SCK so the far end can oversample it with the same clk.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period (and per SS setup, hold and gap). Legal range is 2..255. Use 4 or more when the slave oversamples SCK with a register plus edge detect.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- start  input  1  request a transfer; sampled only while busy=0.
- din  input  8  byte to transmit; latched on the accepted start cycle.
- miso  input  1  serial data from the slave.
- sck  output  1  SPI clock, idles low.
- mosi  output  1  serial data to the slave.
- ss  output  1  slave select, active-low.
- busy  output  1  high from the start-accept edge until the transfer and gap complete.
- done  output  1  one-cycle pulse when dout is updated.
- dout  output  8  last received byte; holds until the next done.

Behaviour:
- Reset values (rst=0, asynchronous): sck=0, ss=1, mosi=0, busy=0, done=0, dout=0x00. Internal state: IDLE, divider=0, bit count=0.
- States and transitions:
  - IDLE → SETUP → SHIFT_HI ⇄ SHIFT_LO → GAP → IDLE.
  - Every timed state lasts exactly CLK_DIV clk cycles, counted by an 8-bit divider that reloads on each state change.
- Start accept, edge E0 (IDLE with start=1):
  - Latch din into the TX shift register.
  - ss←0, mosi←din[7], busy←1, bit count←0; go to SETUP.
- SCK rising edges, k=0..7:
  - Occur at E0+CLK_DIV*(1+2k); sck←1.
  - On the same edge, shift miso into the LSB of the RX shift register and increment the bit count.
  - miso is sampled directly, with no synchronizer, because the slave drives it from the same clk.
- SCK falling edges, k=0..7:
  - Occur at E0+CLK_DIV*(2+2k); sck←0.
  - For k<7, mosi←TX bit (6-k). At k=7, mosi holds its last value.
- Completion at E0+17*CLK_DIV (end of the final low phase, which is the SS hold time):
  - ss←1, dout←RX byte, done←1 for exactly one cycle; enter GAP.
- End of GAP at E0+18*CLK_DIV: busy←0, return to IDLE.
  - Guarantees ss is high for at least CLK_DIV cycles between transfers.
- Timing summary: exactly 8 SCK rising edges per transfer. done always coincides with the ss rising edge. done never asserts outside that cycle.
- start while busy=1: ignored, with no queueing. din changes while busy have no effect.
- start held high continuously: a new transfer is accepted on the first cycle with busy=0, i.e. the IDLE cycle. Transfers repeat every 18*CLK_DIV+1 cycles.
- Reset asserted mid-transfer:
  - Outputs return to reset values immediately; ss rising aborts the slave's byte.
  - dout is cleared to 0x00 and done does not pulse.
  - After release, the block is in IDLE and responds to start on the first clk edge.
- Widths: bit count is 4 bits (0..8), divider is 8 bits, no arithmetic overflow paths. CLK_DIV<2 is illegal; flag it with an elaboration-time check.

Test Plan:
- Loopback (miso wired to mosi), CLK_DIV=4, din=0xA5, 1-cycle start → dout=0xA5, done at start edge +68 cycles, busy low at +72. The monitor counts exactly 8 sck rising edges while ss=0, and mosi bits read 1,0,1,0,0,1,0,1 at those edges.
- Behavioural mode-0 slave model preloaded with 0x3C, master din=0xC3 → master dout=0x3C, slave receives 0xC3, done pulse exactly 1 cycle wide and aligned with ss rising.
- miso tied 1, din=0x00 → dout=0xFF, mosi=0 at all 8 rising edges. Then miso tied 0, din=0xFF → dout=0x00.
- start re-pulsed at +10 and +40 cycles during a transfer of 0x5A → ignored: single done, sck edge count still 8, dout unchanged by the extra pulses.
- rst driven low at +30 cycles mid-transfer → same-cycle ss=1, sck=0, busy=0, done never pulses, dout=0x00. After release, start with din=0x81 completes normally and returns 0x81 in loopback.
- CLK_DIV=2, start held high, din=0x11 then 0x22 → two back-to-back transfers 37 cycles apart, ss high for at least 2 cycles between them, dout sequence 0x11 then 0x22 in loopback.
